req_gnt_responder: RTL
======================

Name: req_gnt_responder

Overview:
- Grant-side responder for the req/gnt handshake.
- Detects a rising edge on req and returns a single-cycle gnt within a bounded latency. This keeps the req |-> ##[1:MAX_LAT] gnt property satisfied and exercised.
- Maintains request and grant event counters so a bench can prove the antecedent actually fired, i.e. the pass was non-vacuous.
- Sits opposite a requester, as the gnt driver for any block checked by that property.

Parameters:
- MAX_LAT, 3: maximum req-rise-to-gnt latency in cycles; must be >= 1.
- CNT_W, 8: width of the rise and grant event counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- req  input  1  request; only its rising edge is significant.
- lat  input  2  requested latency, sampled on the rise-detect edge.
- busy  input  1  stall; while high, gnt is not issued.
- gnt  output  1  grant; registered, high for exactly one cycle per accepted request.
- timeout  output  1  registered one-cycle pulse when the MAX_LAT deadline is missed.
- rise_cnt  output  CNT_W  number of req rising edges detected; saturating.
- gnt_cnt  output  CNT_W  number of grants issued; saturating.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - gnt=0, timeout=0, rise_cnt=0, gnt_cnt=0, FSM=IDLE, elapsed=0.
  - Internal req_q resets to 1, so a req already high at reset release is not a rise.
- Reset asserted mid-operation:
  - All state clears immediately; gnt and timeout drop without waiting for a clock edge.
  - The pending request is discarded.
- Rise detection: rise = req & ~req_q, evaluated at each posedge; req_q <= req every cycle.
- Effective latency L, latched at the rise edge E0:
  - lat==0 gives L=1.
  - lat>MAX_LAT gives L=MAX_LAT.
  - Otherwise L=lat.
- Counting convention: E0 is the edge where the rise is seen; Ek is the k-th following edge.
- Grant timing: gnt is sampled high at E_L when busy is low, i.e. the gnt register is set at edge E_(L-1).
- FSM states:
  - IDLE: on rise, latch L and set elapsed=0. If L==1 and busy==0, set gnt at E0 and go to GRANT; otherwise go to WAIT.
  - WAIT: elapsed increments each edge.
    - At edge E_k with k>=L-1 and busy==0: set gnt and go to GRANT.
    - At edge E_(MAX_LAT-1) with busy==1: no grant; set timeout for one cycle and go to IDLE.
  - GRANT: clear gnt after one cycle and go to IDLE.
- Busy semantics: busy defers the grant to the first edge at or after E_(L-1) where busy is low, never beyond E_(MAX_LAT-1).
- Rises seen in WAIT or GRANT:
  - Counted in rise_cnt.
  - Otherwise ignored: not queued and no grant.
- req falling during WAIT does not cancel the request; the grant is still issued.
- A rise in the same cycle the FSM returns to IDLE from GRANT is ignored, since the state is still GRANT at that edge.
- rise_cnt increments on every detected rise.
- gnt_cnt increments on the edge that sets gnt.
- Both counters saturate at all-ones and never wrap.
- timeout and gnt are never high in the same cycle.

Test Plan:
- Vacuity check: release rst, hold req=0 for 10 cycles -> gnt never high; rise_cnt=0 and gnt_cnt=0 flag the run as vacuous.
- Latency sweep: busy=0; for lat=2, one-cycle req pulse seen at E0 -> gnt high only at E2; lat=0 -> gnt at E1; lat=3 -> gnt at E3; gnt_cnt=3 after all three.
- Busy stall: lat=1, busy=1 at E0 and E1, low at E2 -> gnt high at E3. Repeat with busy=1 through E2 -> timeout high at E3, no gnt, gnt_cnt unchanged.
- Overlap and req drop: lat=3, req rises at E0, drops at E1, rises again at E2 -> single gnt at E3; rise_cnt=2, gnt_cnt=1.
- Reset: assert rst while in WAIT -> gnt and counters 0 immediately, no later gnt. Hold req=1 across rst release -> rise_cnt stays 0.
- Saturation: CNT_W=2, five separate granted requests -> rise_cnt=3, gnt_cnt=3, no wrap.

Source files
------------

// File: rtl/req_gnt_responder.sv
// Grant-side responder for a req/gnt handshake.
// Detects a rising edge on req and answers with a single-cycle gnt within
// MAX_LAT cycles. The requested latency is clamped to [1, MAX_LAT]. busy
// defers the grant. If busy is still high at the deadline, a one-cycle
// timeout pulse is raised instead of a grant. Saturating counters record
// detected rises and issued grants, so a checker can tell that its
// antecedent really fired.
module req_gnt_responder #(
  parameter int MAX_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       lat,
  input  logic             busy,
  output logic             gnt,
  output logic             timeout,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] gnt_cnt
);

  // Width that holds any effective latency and any elapsed count.
  localparam int EW = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            req_q;
  logic            rise;
  logic [EW-1:0]   elapsed;
  logic [EW-1:0]   elapsed_nxt;
  logic [EW-1:0]   lat_q;
  logic [EW-1:0]   lat_nxt;
  logic [EW-1:0]   lat_now;
  logic            gnt_nxt;
  logic            timeout_nxt;
  int              k_edge;

  // Clamp the requested latency into [1, MAX_LAT]. A request of 0 means
  // "as soon as possible", which is one cycle.
  function automatic logic [EW-1:0] eff_lat(input logic [1:0] l);
    int v;
    v = int'(l);
    if (v == 0) begin
      v = 1;
    end else if (v > MAX_LAT) begin
      v = MAX_LAT;
    end
    return EW'(v);
  endfunction

  // Increment that sticks at all-ones so a long run never wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  assign rise    = req & ~req_q;
  assign lat_now = eff_lat(lat);

  // Index of the edge being evaluated in WAIT. elapsed is 0 after E0, so
  // the edge being decided now is E_(elapsed+1).
  assign k_edge  = int'(elapsed) + 1;

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt   = state;
    elapsed_nxt = elapsed;
    lat_nxt     = lat_q;
    gnt_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          lat_nxt     = lat_now;
          elapsed_nxt = '0;
          if (!busy && (lat_now == EW'(1))) begin
            // One-cycle latency: gnt goes up on this very edge.
            gnt_nxt   = 1'b1;
            state_nxt = GRANT;
          end else if (MAX_LAT <= 1) begin
            // E0 is already the deadline when MAX_LAT is 1.
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!busy && (k_edge >= int'(lat_q) - 1)) begin
          gnt_nxt   = 1'b1;
          state_nxt = GRANT;
        end else if (k_edge >= MAX_LAT - 1) begin
          // Deadline edge reached with busy still high.
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          elapsed_nxt = elapsed + EW'(1);
        end
      end
      GRANT: begin
        // gnt was high for this cycle. Drop it and return to idle.
        // A rise seen on this edge is counted but not served.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Edge detector, latched latency and elapsed-cycle tracking.
  // req_q resets high so that a req already high at reset release is not
  // treated as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b1;
      lat_q   <= EW'(1);
      elapsed <= '0;
    end else begin
      req_q   <= req;
      lat_q   <= lat_nxt;
      elapsed <= elapsed_nxt;
    end
  end

  // Registered gnt and timeout pulses. Both are mutually exclusive by
  // construction of the decode above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      gnt     <= gnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Saturating event counters. Every detected rise is counted, including
  // rises ignored in WAIT or GRANT. A grant is counted on the edge that
  // sets gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt <= '0;
      gnt_cnt  <= '0;
    end else begin
      if (rise) begin
        rise_cnt <= sat_inc(rise_cnt);
      end
      if (gnt_nxt) begin
        gnt_cnt <= sat_inc(gnt_cnt);
      end
    end
  end

endmodule
